// File: rtl/timer_unit_if.sv
// Register-write, control and status bundle for timer_unit.
// The slave side is the timer; the master side is whatever drives the control inputs.
interface timer_unit_if;
  logic        timer_en;
  logic        psc_we;
  logic [15:0] TIM_PSC;
  logic        arr_we;
  logic [15:0] TIM_ARR;
  logic        ug;
  logic        uif_clr;
  logic        uie;
  logic [15:0] tim_cnt;
  logic        uev;
  logic        uif;
  logic        irq;
  logic        running;

  modport slave (
    input  timer_en, psc_we, TIM_PSC, arr_we, TIM_ARR, ug, uif_clr, uie,
    output tim_cnt, uev, uif, irq, running
  );

  modport master (
    output timer_en, psc_we, TIM_PSC, arr_we, TIM_ARR, ug, uif_clr, uie,
    input  tim_cnt, uev, uif, irq, running
  );
endinterface

// File: rtl/timer_unit.sv
// Up-counting timer with a prescaler, preloaded PSC/ARR shadows and an update event.
// It also provides a sticky update flag and an interrupt request.
module timer_unit #(
  parameter logic ARPE = 1'b1
) (
  input logic         clk,
  input logic         reset,
  timer_unit_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] psc_pre_q, psc_pre_d;
  logic [15:0] psc_act_q, psc_act_d;
  logic [15:0] arr_pre_q, arr_pre_d;
  logic [15:0] arr_act_q, arr_act_d;
  logic [15:0] psc_cnt_q, psc_cnt_d;
  logic [15:0] cnt_q, cnt_d;
  logic        uev_q, uev_d;
  logic        uif_q, uif_d;

  logic run_s;
  logic tick_s;
  logic wrap_s;
  logic upd_s;

  // Counting is gated by the registered state, so the edge that samples timer_en low still counts.
  assign run_s  = (state_q == RUN);
  assign tick_s = run_s && (psc_cnt_q == psc_act_q);
  assign wrap_s = tick_s && (cnt_q == arr_act_q);
  assign upd_s  = bus.ug || wrap_s;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.timer_en)  state_d = RUN;  else state_d = IDLE;
      RUN:     if (!bus.timer_en) state_d = IDLE; else state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: prescaler, counter, shadow registers and flags
  always_comb begin
    psc_cnt_d = psc_cnt_q;
    cnt_d     = cnt_q;
    psc_pre_d = psc_pre_q;
    psc_act_d = psc_act_q;
    arr_pre_d = arr_pre_q;
    arr_act_d = arr_act_q;

    if (bus.ug) begin
      psc_cnt_d = 16'h0000;
      cnt_d     = 16'h0000;
    end else if (tick_s) begin
      psc_cnt_d = 16'h0000;
      // An ARR lowered below cnt lets cnt run on through 16'hFFFF and wrap silently.
      if (wrap_s) cnt_d = 16'h0000;
      else        cnt_d = cnt_q + 16'h0001;
    end else if (run_s) begin
      psc_cnt_d = psc_cnt_q + 16'h0001;
    end else begin
      psc_cnt_d = psc_cnt_q;
    end

    if (bus.psc_we) psc_pre_d = bus.TIM_PSC;
    else            psc_pre_d = psc_pre_q;
    if (bus.arr_we) arr_pre_d = bus.TIM_ARR;
    else            arr_pre_d = arr_pre_q;

    // Shadows take the preload value held before this edge; a same-edge write waits for the next update.
    if (upd_s) psc_act_d = psc_pre_q;
    else       psc_act_d = psc_act_q;

    if (ARPE && upd_s)            arr_act_d = arr_pre_q;
    else if (!ARPE && bus.arr_we) arr_act_d = bus.TIM_ARR;
    else                          arr_act_d = arr_act_q;

    uev_d = upd_s;
    if (upd_s)            uif_d = 1'b1;
    else if (bus.uif_clr) uif_d = 1'b0;
    else                  uif_d = uif_q;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      psc_pre_q <= 16'h0000;
      psc_act_q <= 16'h0000;
      arr_pre_q <= 16'hFFFF;
      arr_act_q <= 16'hFFFF;
      psc_cnt_q <= 16'h0000;
      cnt_q     <= 16'h0000;
      uev_q     <= 1'b0;
      uif_q     <= 1'b0;
    end else begin
      psc_pre_q <= psc_pre_d;
      psc_act_q <= psc_act_d;
      arr_pre_q <= arr_pre_d;
      arr_act_q <= arr_act_d;
      psc_cnt_q <= psc_cnt_d;
      cnt_q     <= cnt_d;
      uev_q     <= uev_d;
      uif_q     <= uif_d;
    end
  end

  assign bus.tim_cnt = cnt_q;
  assign bus.uev     = uev_q;
  assign bus.uif     = uif_q;
  assign bus.irq     = uif_q & bus.uie;
  assign bus.running = run_s;

endmodule

// File: tb/tb_timer_unit.sv
// Directed bench for timer_unit: two instances (ARPE=1 and ARPE=0) share one stimulus.
module tb_timer_unit;
  logic        clk;
  logic        reset;
  logic        timer_en, psc_we, arr_we, ug, uif_clr, uie;
  logic [15:0] tim_psc, tim_arr;
  int          checks;
  int          failures;

  timer_unit_if bus_a ();
  timer_unit_if bus_b ();

  assign bus_a.timer_en = timer_en;
  assign bus_a.psc_we   = psc_we;
  assign bus_a.TIM_PSC  = tim_psc;
  assign bus_a.arr_we   = arr_we;
  assign bus_a.TIM_ARR  = tim_arr;
  assign bus_a.ug       = ug;
  assign bus_a.uif_clr  = uif_clr;
  assign bus_a.uie      = uie;
  assign bus_b.timer_en = timer_en;
  assign bus_b.psc_we   = psc_we;
  assign bus_b.TIM_PSC  = tim_psc;
  assign bus_b.arr_we   = arr_we;
  assign bus_b.TIM_ARR  = tim_arr;
  assign bus_b.ug       = ug;
  assign bus_b.uif_clr  = uif_clr;
  assign bus_b.uie      = uie;

  timer_unit #(.ARPE(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  timer_unit #(.ARPE(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_regs(input logic [15:0] p, input logic [15:0] a);
    tim_psc = p;
    tim_arr = a;
    psc_we  = 1'b1;
    arr_we  = 1'b1;
    tick(1);
    psc_we  = 1'b0;
    arr_we  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick(2);
    checks++; if (bus_a.tim_cnt !== 16'h0000) begin failures++; $display("FAIL reset_cnt got=%0h exp=0", bus_a.tim_cnt); end
    checks++; if (bus_a.uev !== 1'b0) begin failures++; $display("FAIL reset_uev got=%b exp=0", bus_a.uev); end
    checks++; if (bus_a.uif !== 1'b0) begin failures++; $display("FAIL reset_uif got=%b exp=0", bus_a.uif); end
    checks++; if (bus_a.irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", bus_a.irq); end
    checks++; if (bus_a.running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", bus_a.running); end
    reset = 1'b1;
  endtask

  task automatic test_basic;
    write_regs(16'd2, 16'd3);
    ug = 1'b1;
    tick(1);
    ug = 1'b0;
    checks++; if (bus_a.uev !== 1'b1) begin failures++; $display("FAIL basic_ug_uev got=%b exp=1", bus_a.uev); end
    checks++; if (bus_a.uif !== 1'b1) begin failures++; $display("FAIL basic_ug_uif got=%b exp=1", bus_a.uif); end
    uif_clr = 1'b1;
    tick(1);
    uif_clr = 1'b0;
    checks++; if (bus_a.uif !== 1'b0) begin failures++; $display("FAIL basic_clr_uif got=%b exp=0", bus_a.uif); end
    timer_en = 1'b1;
    tick(1);
    checks++; if (bus_a.running !== 1'b1) begin failures++; $display("FAIL basic_running got=%b exp=1", bus_a.running); end
    checks++; if (bus_a.tim_cnt !== 16'd0) begin failures++; $display("FAIL basic_start_cnt got=%0d exp=0", bus_a.tim_cnt); end
    for (int k = 1; k <= 24; k++) begin
      tick(1);
      checks++; if (bus_a.tim_cnt !== 16'((k / 3) % 4)) begin failures++; $display("FAIL basic_cnt k=%0d got=%0d exp=%0d", k, bus_a.tim_cnt, (k / 3) % 4); end
      checks++; if (bus_a.uev !== ((k % 12) == 0)) begin failures++; $display("FAIL basic_uev k=%0d got=%b exp=%b", k, bus_a.uev, ((k % 12) == 0)); end
    end
    checks++; if (bus_a.uif !== 1'b1) begin failures++; $display("FAIL basic_uif got=%b exp=1", bus_a.uif); end
  endtask

  task automatic test_preload;
    int ea, eb;
    tim_arr = 16'd7;
    arr_we  = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      tick(1);
      arr_we = 1'b0;
      ea = (k < 12) ? (k / 3) : (((k - 12) / 3) % 8);
      eb = (k / 3) % 8;
      checks++; if (bus_a.tim_cnt !== 16'(ea)) begin failures++; $display("FAIL preload_a_cnt k=%0d got=%0d exp=%0d", k, bus_a.tim_cnt, ea); end
      checks++; if (bus_a.uev !== (k == 12 || k == 36)) begin failures++; $display("FAIL preload_a_uev k=%0d got=%b", k, bus_a.uev); end
      checks++; if (bus_b.tim_cnt !== 16'(eb)) begin failures++; $display("FAIL preload_b_cnt k=%0d got=%0d exp=%0d", k, bus_b.tim_cnt, eb); end
      checks++; if (bus_b.uev !== (k == 24)) begin failures++; $display("FAIL preload_b_uev k=%0d got=%b", k, bus_b.uev); end
    end
  endtask

  task automatic test_hold;
    write_regs(16'd2, 16'd3);
    ug = 1'b1;
    tick(1);
    ug = 1'b0;
    tick(7);
    checks++; if (bus_a.tim_cnt !== 16'd2) begin failures++; $display("FAIL hold_pre_cnt got=%0d exp=2", bus_a.tim_cnt); end
    // The disabling edge still advances the prescaler once (psc_cnt 1 -> 2).
    timer_en = 1'b0;
    tick(1);
    checks++; if (bus_a.running !== 1'b0) begin failures++; $display("FAIL hold_running got=%b exp=0", bus_a.running); end
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++; if (bus_a.tim_cnt !== 16'd2 || bus_a.running !== 1'b0) begin failures++; $display("FAIL hold_idle i=%0d cnt=%0d running=%b exp cnt=2 running=0", i, bus_a.tim_cnt, bus_a.running); end
    end
    timer_en = 1'b1;
    tick(1);
    checks++; if (bus_a.running !== 1'b1 || bus_a.tim_cnt !== 16'd2) begin failures++; $display("FAIL hold_resume running=%b cnt=%0d exp 1/2", bus_a.running, bus_a.tim_cnt); end
    tick(1);
    checks++; if (bus_a.tim_cnt !== 16'd3) begin failures++; $display("FAIL hold_first_tick got=%0d exp=3", bus_a.tim_cnt); end
    tick(2);
    checks++; if (bus_a.tim_cnt !== 16'd3 || bus_a.uev !== 1'b0) begin failures++; $display("FAIL hold_before_wrap cnt=%0d uev=%b exp 3/0", bus_a.tim_cnt, bus_a.uev); end
    tick(1);
    checks++; if (bus_a.tim_cnt !== 16'd0 || bus_a.uev !== 1'b1) begin failures++; $display("FAIL hold_wrap cnt=%0d uev=%b exp 0/1", bus_a.tim_cnt, bus_a.uev); end
  endtask

  task automatic test_flags;
    uie     = 1'b1;
    uif_clr = 1'b1;
    tick(1);
    uif_clr = 1'b0;
    checks++; if (bus_a.uif !== 1'b0 || bus_a.irq !== 1'b0) begin failures++; $display("FAIL flags_clear uif=%b irq=%b exp 0/0", bus_a.uif, bus_a.irq); end
    tick(11);
    checks++; if (bus_a.uev !== 1'b1 || bus_a.uif !== 1'b1 || bus_a.irq !== 1'b1) begin failures++; $display("FAIL flags_irq uev=%b uif=%b irq=%b exp 1/1/1", bus_a.uev, bus_a.uif, bus_a.irq); end
    tick(11);
    uif_clr = 1'b1;
    tick(1);
    checks++; if (bus_a.uev !== 1'b1 || bus_a.uif !== 1'b1) begin failures++; $display("FAIL flags_set_wins uev=%b uif=%b exp 1/1", bus_a.uev, bus_a.uif); end
    tick(1);
    uif_clr = 1'b0;
    checks++; if (bus_a.uif !== 1'b0 || bus_a.irq !== 1'b0) begin failures++; $display("FAIL flags_clr_alone uif=%b irq=%b exp 0/0", bus_a.uif, bus_a.irq); end
  endtask

  task automatic test_edges;
    logic saw;
    timer_en = 1'b0;
    tick(1);
    write_regs(16'd0, 16'd0);
    ug = 1'b1;
    tick(1);
    ug = 1'b0;
    timer_en = 1'b1;
    tick(1);
    checks++; if (bus_a.running !== 1'b1 || bus_a.uev !== 1'b0) begin failures++; $display("FAIL edge0_start running=%b uev=%b exp 1/0", bus_a.running, bus_a.uev); end
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checks++; if (bus_a.uev !== 1'b1 || bus_a.tim_cnt !== 16'd0) begin failures++; $display("FAIL edge0_every i=%0d uev=%b cnt=%0d exp 1/0", i, bus_a.uev, bus_a.tim_cnt); end
    end
    timer_en = 1'b0;
    tick(1);
    write_regs(16'd0, 16'hFFFF);
    ug = 1'b1;
    tick(1);
    ug = 1'b0;
    timer_en = 1'b1;
    tick(1);
    tick(10);
    checks++; if (bus_b.tim_cnt !== 16'd10) begin failures++; $display("FAIL edge_oor_at10 got=%0d exp=10", bus_b.tim_cnt); end
    tim_arr = 16'd5;
    arr_we  = 1'b1;
    tick(1);
    arr_we  = 1'b0;
    checks++; if (bus_b.tim_cnt !== 16'd11) begin failures++; $display("FAIL edge_oor_lower got=%0d exp=11", bus_b.tim_cnt); end
    saw = 1'b0;
    for (int i = 0; i < 65524; i++) begin
      tick(1);
      if (bus_b.uev === 1'b1) saw = 1'b1;
    end
    checks++; if (bus_b.tim_cnt !== 16'hFFFF || saw !== 1'b0) begin failures++; $display("FAIL edge_oor_top cnt=%0h saw_uev=%b exp ffff/0", bus_b.tim_cnt, saw); end
    tick(1);
    checks++; if (bus_b.tim_cnt !== 16'd0 || bus_b.uev !== 1'b0) begin failures++; $display("FAIL edge_oor_wrap cnt=%0h uev=%b exp 0/0", bus_b.tim_cnt, bus_b.uev); end
    checks++; if (bus_a.uev !== 1'b1) begin failures++; $display("FAIL edge_arpe1_wrap uev=%b exp 1", bus_a.uev); end
    tick(5);
    checks++; if (bus_b.tim_cnt !== 16'd5 || bus_b.uev !== 1'b0) begin failures++; $display("FAIL edge_oor_at5 cnt=%0d uev=%b exp 5/0", bus_b.tim_cnt, bus_b.uev); end
    tick(1);
    checks++; if (bus_b.tim_cnt !== 16'd0 || bus_b.uev !== 1'b1) begin failures++; $display("FAIL edge_oor_first_uev cnt=%0d uev=%b exp 0/1", bus_b.tim_cnt, bus_b.uev); end
  endtask

  task automatic test_reset_mid;
    logic saw;
    write_regs(16'd0, 16'd9);
    ug = 1'b1;
    tick(1);
    ug = 1'b0;
    tick(5);
    checks++; if (bus_a.tim_cnt !== 16'd5) begin failures++; $display("FAIL rmid_pre_cnt got=%0d exp=5", bus_a.tim_cnt); end
    reset   = 1'b0;
    ug      = 1'b1;
    tim_arr = 16'd2;
    arr_we  = 1'b1;
    tick(1);
    checks++; if (bus_a.tim_cnt !== 16'd0 || bus_a.uev !== 1'b0 || bus_a.uif !== 1'b0) begin failures++; $display("FAIL rmid_a cnt=%0d uev=%b uif=%b exp 0/0/0", bus_a.tim_cnt, bus_a.uev, bus_a.uif); end
    checks++; if (bus_a.irq !== 1'b0 || bus_a.running !== 1'b0) begin failures++; $display("FAIL rmid_a_irq irq=%b running=%b exp 0/0", bus_a.irq, bus_a.running); end
    checks++; if (bus_b.tim_cnt !== 16'd0 || bus_b.uev !== 1'b0) begin failures++; $display("FAIL rmid_b cnt=%0d uev=%b exp 0/0", bus_b.tim_cnt, bus_b.uev); end
    reset  = 1'b1;
    ug     = 1'b0;
    arr_we = 1'b0;
    tick(1);
    checks++; if (bus_a.running !== 1'b1 || bus_a.tim_cnt !== 16'd0) begin failures++; $display("FAIL rmid_restart running=%b cnt=%0d exp 1/0", bus_a.running, bus_a.tim_cnt); end
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (bus_a.uev === 1'b1 || bus_b.uev === 1'b1) saw = 1'b1;
    end
    checks++; if (bus_a.tim_cnt !== 16'd12 || bus_b.tim_cnt !== 16'd12 || saw !== 1'b0) begin failures++; $display("FAIL rmid_defaults a=%0d b=%0d saw_uev=%b exp 12/12/0", bus_a.tim_cnt, bus_b.tim_cnt, saw); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    timer_en = 1'b0;
    psc_we   = 1'b0;
    arr_we   = 1'b0;
    ug       = 1'b0;
    uif_clr  = 1'b0;
    uie      = 1'b0;
    tim_psc  = 16'h0000;
    tim_arr  = 16'h0000;
    #2;
    test_reset;
    test_basic;
    test_preload;
    test_hold;
    test_flags;
    test_edges;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
